// File: rtl/cbus_mem_responder.sv
// Memory-side responder for the simplified burst cache bus: accepts one request at a
// time, waits a fixed latency, then streams read or write beats against a word memory.

package cbus_pkg;

    typedef enum logic [1:0] {
        CBUS_FIXED = 2'd0,
        CBUS_INCR  = 2'd1,
        CBUS_WRAP  = 2'd2,
        CBUS_RSVD  = 2'd3
    } cbus_burst_e;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        cbus_burst_e burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// Handshake: a request is accepted on the first rising edge in IDLE with creq.valid=1.
// Each cycle with cresp.ready=1 is one beat; the master must keep valid high through
// last, and dropping valid before then aborts the burst without committing that beat.
module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  beat_q, beat_d;
    logic        wr_q, wr_d;
    logic [2:0]  size_q, size_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    cbus_burst_e burst_q, burst_d;

    logic [63:0] mem_q [MEM_WORDS];

    logic [63:0] step;
    logic [63:0] incr_addr;
    logic [15:0] window;
    logic [63:0] wrap_mask;
    logic [63:0] beat_addr;
    logic [63:0] offs;
    logic        in_range;
    logic [IDX_W-1:0] mem_idx;
    logic        in_burst;
    logic        mem_we;

    // ------------------------------------------------------------------
    // Beat address generation
    // ------------------------------------------------------------------
    always_comb begin
        step      = 64'(beat_q) << size_q;
        incr_addr = addr_q + step;
        window    = ({8'd0, len_q} + 16'd1) << size_q;
    end

    // Wrap window is the largest power of two not above (len+1)*B.
    always_comb begin
        wrap_mask = '0;
        for (int b = 0; b < 16; b++) begin
            if (window[b]) begin
                wrap_mask = (64'd1 << b) - 64'd1;
            end
        end
    end

    always_comb begin
        case (burst_q)
            CBUS_FIXED: beat_addr = addr_q;
            CBUS_WRAP:  beat_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    beat_addr = incr_addr;
        endcase
    end

    always_comb begin
        offs     = beat_addr - BASE_ADDR;
        in_range = (beat_addr >= BASE_ADDR) && ((offs >> 3) < 64'(MEM_WORDS));
        mem_idx  = offs[IDX_W+2:3];
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= CBUS_FIXED;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        case (state_q)
            S_IDLE: begin
                if (creq.valid) begin
                    wr_d    = creq.is_write;
                    size_d  = creq.size;
                    addr_d  = creq.addr;
                    len_d   = creq.len;
                    burst_d = creq.burst;
                    wait_d  = WAIT_INIT;
                    beat_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!creq.valid) begin
                    state_d = S_IDLE;
                end else if (wait_q == 4'd0) begin
                    beat_d  = '0;
                    state_d = S_BURST;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_BURST: begin
                // The 8-bit index stops at len, so len=255 gives 256 beats without wrapping.
                if (!creq.valid || beat_q == len_q) begin
                    beat_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Backing store and response
    // ------------------------------------------------------------------
    assign in_burst = (state_q == S_BURST);
    assign mem_we   = in_burst && wr_q && creq.valid && in_range && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (creq.strobe[k]) begin
                    mem_q[mem_idx][8*k +: 8] <= creq.data[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        cresp.ready = in_burst;
        cresp.last  = in_burst && (beat_q == len_q);
        cresp.data  = (in_burst && !wr_q && in_range) ? mem_q[mem_idx] : 64'd0;
    end

endmodule
